// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: states, opcodes, mux selects, strobe bundle.
// MC_ILLEGAL_TRAP_EN adds the TRAP state.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I,
    ALU_WB, BRANCH, JALR_ADR, JUMP, ILLEGAL
`ifdef MC_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_I      = 7'd19;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;

  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3;
  localparam logic [2:0] ALUOP_ADD = 3'd0, ALUOP_SUB = 3'd1, ALUOP_FUNCT = 3'd2;
  localparam logic [1:0] RES_ALUOUT = 2'd0, RES_MEM = 2'd1, RES_ALU = 2'd2;
  localparam logic [1:0] SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RS1 = 2'd2;
  localparam logic [1:0] SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_req;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic       jalr;
    logic       trap;
  } ctl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle; master is the sequencer, slave is the datapath side.
interface multicycle_ctrl_fsm_if #(parameter int INSTRET_W = 32);
  logic [6:0]           opcode;
  logic                 eq;
  logic                 mem_ready;
  logic                 pc_write, ir_write, adr_src, mem_req, mem_write, reg_write;
  logic [1:0]           alu_src_a, alu_src_b, result_src;
  logic [2:0]           alu_op, imm_src;
  logic                 jalr, trap, mem_timeout;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  opcode, eq, mem_ready,
    output pc_write, ir_write, adr_src, mem_req, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_op, imm_src, result_src, jalr, trap,
           mem_timeout, instret
  );

  modport slave (
    output opcode, eq, mem_ready,
    input  pc_write, ir_write, adr_src, mem_req, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_op, imm_src, result_src, jalr, trap,
           mem_timeout, instret
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_watchdog.sv
// Memory stall watchdog: counts consecutive unanswered request cycles, sticky flag at TIMEOUT.
module mc_mem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  output logic timeout_o
);
  logic [15:0] cnt_q, cnt_d;
  logic        flag_q;
  logic        wait_c;

  assign wait_c = mem_req_i && !mem_ready_i;

  // Saturate at TIMEOUT so a very long stall cannot wrap the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (!wait_c)                     cnt_d = '0;
    else if (cnt_q != 16'(TIMEOUT)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_q | (wait_c && cnt_d == 16'(TIMEOUT));
    end
  end

  assign timeout_o = flag_q;
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: Moore strobes per state, mem handshake, retire counter.
// Optional MC_ILLEGAL_TRAP_EN halts in TRAP on an illegal opcode instead of treating it as NOP.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32,
  parameter int TIMEOUT   = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  multicycle_ctrl_fsm_if.master bus
);
  state_e               state_q, state_d;
  ctl_t                 ctl, ctl_o;
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == FETCH && state_q != FETCH) instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    case (state_q)
      FETCH: begin
        ctl.mem_req = 1'b1;
        if (bus.mem_ready) begin
          ctl.ir_write   = 1'b1;
          ctl.pc_write   = 1'b1;
          ctl.alu_src_b  = SRCB_FOUR;
          ctl.result_src = RES_ALU;
          state_d        = DECODE;
        end
      end
      DECODE: begin
        ctl.alu_src_a = SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
        ctl.imm_src   = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = MEM_ADR;
          OP_R:              state_d = EXEC_R;
          OP_I:              state_d = EXEC_I;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JUMP;
          OP_JALR:           state_d = JALR_ADR;
          default:           state_d = ILLEGAL;
        endcase
      end
      MEM_ADR: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.imm_src   = (bus.opcode == OP_LOAD) ? IMM_I : IMM_S;
        state_d       = (bus.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        ctl.mem_req = 1'b1;
        ctl.adr_src = 1'b1;
        if (bus.mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.result_src = RES_MEM;
        state_d        = FETCH;
      end
      MEM_WR: begin
        ctl.mem_req   = 1'b1;
        ctl.mem_write = 1'b1;
        ctl.adr_src   = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXEC_R: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_RS2;
        ctl.alu_op    = ALUOP_FUNCT;
        state_d       = ALU_WB;
      end
      EXEC_I: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.imm_src   = IMM_I;
        ctl.alu_op    = ALUOP_FUNCT;
        state_d       = ALU_WB;
      end
      ALU_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.result_src = RES_ALUOUT;
        state_d        = FETCH;
      end
      BRANCH: begin
        ctl.alu_src_a  = SRCA_RS1;
        ctl.alu_src_b  = SRCB_RS2;
        ctl.alu_op     = ALUOP_SUB;
        ctl.result_src = RES_ALUOUT;
        ctl.pc_write   = bus.eq;
        state_d        = FETCH;
      end
      JALR_ADR: begin
        ctl.alu_src_a = SRCA_RS1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.imm_src   = IMM_I;
        ctl.alu_op    = ALUOP_ADD;
        ctl.jalr      = 1'b1;
        state_d       = JUMP;
      end
      // ALUOut holds the target; the ALU meanwhile forms old_pc+4 for the link write.
      JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.result_src = RES_ALUOUT;
        ctl.alu_src_a  = SRCA_OLDPC;
        ctl.alu_src_b  = SRCB_FOUR;
        state_d        = ALU_WB;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      ILLEGAL: state_d = TRAP;
      TRAP:    ctl.trap = 1'b1;
`else
      ILLEGAL: state_d = FETCH;
`endif
      default: state_d = FETCH;
    endcase
  end

  // Strobes are forced low for the whole time reset is asserted, not just after the edge.
  assign ctl_o = rst_n ? ctl : '0;

  assign bus.pc_write   = ctl_o.pc_write;
  assign bus.ir_write   = ctl_o.ir_write;
  assign bus.adr_src    = ctl_o.adr_src;
  assign bus.mem_req    = ctl_o.mem_req;
  assign bus.mem_write  = ctl_o.mem_write;
  assign bus.reg_write  = ctl_o.reg_write;
  assign bus.alu_src_a  = ctl_o.alu_src_a;
  assign bus.alu_src_b  = ctl_o.alu_src_b;
  assign bus.alu_op     = ctl_o.alu_op;
  assign bus.imm_src    = ctl_o.imm_src;
  assign bus.result_src = ctl_o.result_src;
  assign bus.jalr       = ctl_o.jalr;
  assign bus.trap       = ctl_o.trap;
  assign bus.instret    = instret_q;

  mc_mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req_i  (ctl_o.mem_req),
    .mem_ready_i(bus.mem_ready),
    .timeout_o  (bus.mem_timeout)
  );
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Table-driven bench for multicycle_ctrl_fsm with a scoreboard queue of per-cycle expectations.
module tb_multicycle_ctrl_fsm;
  typedef struct packed {
    logic [6:0]  op;
    logic        eq;
    logic        rdy;
    logic [19:0] exp;
    logic [31:0] inst;
    logic        tmo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.INSTRET_W(32)) bus ();
  multicycle_ctrl_fsm #(.INSTRET_W(32), .TIMEOUT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Order: pcw irw adr req mw rw | a b op imm res | jalr trap
  function automatic logic [19:0] s(logic pcw, logic irw, logic adr, logic req, logic mw,
                                    logic rw, int a, int b, int op, int imm, int res,
                                    logic jl, logic tr);
    return {pcw, irw, adr, req, mw, rw, a[1:0], b[1:0], op[2:0], imm[2:0], res[1:0], jl, tr};
  endfunction

  function automatic logic [19:0] act();
    return {bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_req, bus.mem_write,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src,
            bus.result_src, bus.jalr, bus.trap};
  endfunction

  function automatic vec_t mk(int op, logic eq, logic rdy, logic [19:0] e, int inst, logic tmo);
    vec_t v;
    v.op = op[6:0]; v.eq = eq; v.rdy = rdy; v.exp = e; v.inst = inst; v.tmo = tmo;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, want);
  endtask

  task automatic step(vec_t v, int idx);
    vec_t e;
    bus.opcode    = v.op;
    bus.eq        = v.eq;
    bus.mem_ready = v.rdy;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("strobes", idx, 32'(act()), 32'(e.exp));
    chk("instret", idx, bus.instret, e.inst);
    chk("mem_timeout", idx, 32'(bus.mem_timeout), 32'(e.tmo));
    @(posedge clk); #1;
  endtask

  logic [19:0] F_W, F_R, DEC, DECJ, MAL, MAS, MRD, MWB, MWR, EXR, EXI, AWB, BR1, BR0, JAD, JMP, TRP;

  initial begin
    F_W  = s(0,0,0,1,0,0, 0,0,0,0,0, 0,0);
    F_R  = s(1,1,0,1,0,0, 0,2,0,0,2, 0,0);
    DEC  = s(0,0,0,0,0,0, 1,1,0,2,0, 0,0);
    DECJ = s(0,0,0,0,0,0, 1,1,0,3,0, 0,0);
    MAL  = s(0,0,0,0,0,0, 2,1,0,0,0, 0,0);
    MAS  = s(0,0,0,0,0,0, 2,1,0,1,0, 0,0);
    MRD  = s(0,0,1,1,0,0, 0,0,0,0,0, 0,0);
    MWB  = s(0,0,0,0,0,1, 0,0,0,0,1, 0,0);
    MWR  = s(0,0,1,1,1,0, 0,0,0,0,0, 0,0);
    EXR  = s(0,0,0,0,0,0, 2,0,2,0,0, 0,0);
    EXI  = s(0,0,0,0,0,0, 2,1,2,0,0, 0,0);
    AWB  = s(0,0,0,0,0,1, 0,0,0,0,0, 0,0);
    BR1  = s(1,0,0,0,0,0, 2,0,1,0,0, 0,0);
    BR0  = s(0,0,0,0,0,0, 2,0,1,0,0, 0,0);
    JAD  = s(0,0,0,0,0,0, 2,1,0,0,0, 1,0);
    JMP  = s(1,0,0,0,0,0, 1,2,0,0,0, 0,0);
    TRP  = s(0,0,0,0,0,0, 0,0,0,0,0, 0,1);

    // lw, memory answers after two wait cycles on both accesses
    tbl.push_back(mk(3,0,0,F_W,0,0)); tbl.push_back(mk(3,0,0,F_W,0,0));
    tbl.push_back(mk(3,0,1,F_R,0,0)); tbl.push_back(mk(3,0,0,DEC,0,0));
    tbl.push_back(mk(3,0,0,MAL,0,0)); tbl.push_back(mk(3,0,0,MRD,0,0));
    tbl.push_back(mk(3,0,0,MRD,0,0)); tbl.push_back(mk(3,0,1,MRD,0,0));
    tbl.push_back(mk(3,0,1,MWB,0,0));
    // add, ready held high (ignored outside request states)
    tbl.push_back(mk(51,0,1,F_R,1,0)); tbl.push_back(mk(51,0,1,DEC,1,0));
    tbl.push_back(mk(51,0,1,EXR,1,0)); tbl.push_back(mk(51,0,1,AWB,1,0));
    // beq taken, then not taken
    tbl.push_back(mk(99,1,1,F_R,2,0)); tbl.push_back(mk(99,1,1,DEC,2,0));
    tbl.push_back(mk(99,1,1,BR1,2,0));
    tbl.push_back(mk(99,0,1,F_R,3,0)); tbl.push_back(mk(99,0,1,DEC,3,0));
    tbl.push_back(mk(99,0,1,BR0,3,0));
    // jalr
    tbl.push_back(mk(103,0,1,F_R,4,0)); tbl.push_back(mk(103,0,1,DEC,4,0));
    tbl.push_back(mk(103,0,1,JAD,4,0)); tbl.push_back(mk(103,0,1,JMP,4,0));
    tbl.push_back(mk(103,0,1,AWB,4,0));
    // sw
    tbl.push_back(mk(35,0,1,F_R,5,0)); tbl.push_back(mk(35,0,1,DEC,5,0));
    tbl.push_back(mk(35,0,1,MAS,5,0)); tbl.push_back(mk(35,0,1,MWR,5,0));
    // jal
    tbl.push_back(mk(111,0,1,F_R,6,0)); tbl.push_back(mk(111,0,1,DECJ,6,0));
    tbl.push_back(mk(111,0,1,JMP,6,0)); tbl.push_back(mk(111,0,1,AWB,6,0));
    // addi
    tbl.push_back(mk(19,0,1,F_R,7,0)); tbl.push_back(mk(19,0,1,DEC,7,0));
    tbl.push_back(mk(19,0,1,EXI,7,0)); tbl.push_back(mk(19,0,1,AWB,7,0));
    // watchdog: six unanswered fetch cycles, flag visible from the fifth on, then sticky
    for (int i = 0; i < 6; i++) tbl.push_back(mk(51,0,0,F_W,8,(i >= 4)));
    tbl.push_back(mk(51,0,1,F_R,8,1)); tbl.push_back(mk(51,0,1,DEC,8,1));
    tbl.push_back(mk(51,0,1,EXR,8,1)); tbl.push_back(mk(51,0,1,AWB,8,1));
    tbl.push_back(mk(3,0,1,F_R,9,1));  tbl.push_back(mk(3,0,1,DEC,9,1));
    tbl.push_back(mk(3,0,1,MAL,9,1));  tbl.push_back(mk(3,0,0,MRD,9,1));

    bus.opcode = '0; bus.eq = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_strobes", 0, 32'(act()), 32'd0);
    chk("rst_instret", 0, bus.instret, 32'd0);
    chk("rst_timeout", 0, 32'(bus.mem_timeout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i], i);

    // Now parked in MEM_RD waiting: reset must drop everything at once.
    rst_n = 1'b0;
    #1;
    chk("midrst_strobes", 1, 32'(act()), 32'd0);
    chk("midrst_instret", 1, bus.instret, 32'd0);
    chk("midrst_timeout", 1, 32'(bus.mem_timeout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(mk(0,0,0,F_W,0,0), 100);
    step(mk(0,0,1,F_R,0,0), 101);
    step(mk(0,0,1,DEC,0,0), 102);
    step(mk(0,0,1,20'd0,0,0), 103);
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) step(mk(0,0,1,TRP,0,0), 104 + i);
`else
    step(mk(0,0,1,F_R,1,0), 104);
    step(mk(0,0,1,DEC,1,0), 105);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
